// File: rtl/alu4bit_pkg.sv
// Shared types and constants for the alu4bit issue controller.
// The issue path is sized for the fixed 4-bit alu4bit datapath.
package alu4bit_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOTA  = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]        sel;
        logic              use_acc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    localparam int REQ_W = 3 + 1 + 2 * DATA_W;

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous request FIFO: head is valid one edge after push (no empty bypass),
// and full is reported purely from the count (no full bypass).
module alu_issue_fifo
    import alu4bit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  req_t                     i_data,
    input  logic                     i_pop,
    output req_t                     o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    req_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // NOTE: storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu4bit_issue_ctrl.sv
// Issue stage for the combinational alu4bit: queues requests, drives registered
// operands for one settle cycle, then holds the captured result until accepted.
module alu4bit_issue_ctrl
    import alu4bit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sel,
    input  logic              in_use_acc,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry,
    output logic              out_zero,
    output logic [DATA_W-1:0] acc,
    output logic              busy
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DATA_W-1:0]       r_alu_a;
    logic [DATA_W-1:0]       r_alu_b;
    logic [2:0]              r_alu_sel;
    logic                    r_out_valid;
    logic [DATA_W-1:0]       r_out_result;
    logic                    r_out_carry;
    logic                    r_out_zero;
    logic [DATA_W-1:0]       r_acc;

    req_t                    w_in_req;
    req_t                    w_head;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_pop;
    logic                    w_capture;
    logic                    w_release;
    logic [DATA_W-1:0]       w_next_a;

    assign w_in_req = '{sel: in_sel, use_acc: in_use_acc, a: in_a, b: in_b};

    alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (in_valid),
        .i_data  (w_in_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Accumulator is read at pop time so a chained op sees the result captured just before.
    assign w_next_a = w_head.use_acc ? r_acc : w_head.a;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_capture    = 1'b1;
                w_state_next = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    w_release = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = EXEC;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= OP_ADD;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_carry  <= 1'b0;
            r_out_zero   <= 1'b0;
            r_acc        <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_alu_sel <= w_head.sel;
                r_alu_b   <= w_head.b;
                r_alu_a   <= w_next_a;
            end
            if (w_capture) begin
                r_out_result <= alu_result;
                r_out_carry  <= alu_carry;
                r_out_zero   <= alu_zero;
                r_acc        <= alu_result;
                r_out_valid  <= 1'b1;
            end else if (w_release) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign in_ready   = ~w_full;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_carry  = r_out_carry;
    assign out_zero   = r_out_zero;
    assign acc        = r_acc;
    assign busy       = (r_state != IDLE) | (w_count != '0);

endmodule
